// File: rtl/aes_pkg.sv
// Shared types for the AES job queue: function codes, the queued job record
// and the issue FSM state encoding.
package aes_pkg;

    localparam int AES_TAGW = 4;

    typedef enum logic [1:0] {
        AES_NONE   = 2'd0,
        AES_ENC    = 2'd1,
        AES_DEC    = 2'd2,
        AES_ENCDEC = 2'd3
    } aes_func_t;

    typedef struct packed {
        logic [AES_TAGW-1:0] tag;
        aes_func_t           func;
        logic [127:0]        key;
        logic [127:0]        text;
    } aes_job_t;

    typedef enum logic [1:0] {
        JQ_IDLE = 2'd0,
        JQ_BUSY = 2'd1,
        JQ_DONE = 2'd2,
        JQ_GAP  = 2'd3
    } jq_state_t;

endpackage

// File: rtl/aes_job_fifo.sv
// Job FIFO with one extra pointer bit so full and empty are distinguished
// without a separate occupancy counter.
module aes_job_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     eph1,
    input  logic     reset,
    input  logic     push,
    input  aes_job_t push_job,
    input  logic     pop,
    output aes_job_t head_job,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    aes_job_t    mem [DEPTH];

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign head_job = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge eph1) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_job;
    end

endmodule

// File: rtl/aes_job_queue.sv
// Request stage for aes_build: buffers jobs, issues them one at a time with
// a watchdog, and returns captured results with the job tag.
module aes_job_queue
    import aes_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TAGW    = AES_TAGW
) (
    input  logic            eph1,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_func,
    input  logic [127:0]    in_key,
    input  logic [127:0]    in_text,
    input  logic [TAGW-1:0] in_tag,
    output logic [1:0]      aes_func,
    output logic [127:0]    aes_key,
    output logic [127:0]    aes_text,
    input  logic            call_complete,
    input  logic [127:0]    ciphertext,
    input  logic [127:0]    plaintext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TAGW-1:0] out_tag,
    output logic [1:0]      out_func,
    output logic [127:0]    out_ct,
    output logic [127:0]    out_pt,
    output logic            out_err,
    output logic [7:0]      drop_cnt
);

    localparam int WDW = $clog2(TIMEOUT) + 1;

    jq_state_t       state;
    logic [WDW-1:0]  wdog;
    logic [TAGW-1:0] cur_tag;
    logic [1:0]      cur_func;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    aes_job_t        push_job;
    aes_job_t        head_job;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_ready = ~fifo_full;
    assign push     = in_valid && in_ready && (in_func != 2'd0);
    assign pop      = (state == JQ_IDLE) && !fifo_empty;

    assign push_job.tag  = AES_TAGW'(in_tag);
    assign push_job.func = aes_func_t'(in_func);
    assign push_job.key  = in_key;
    assign push_job.text = in_text;

    aes_job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .eph1     (eph1),
        .reset    (reset),
        .push     (push),
        .push_job (push_job),
        .pop      (pop),
        .head_job (head_job),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state     <= JQ_IDLE;
            wdog      <= '0;
            cur_tag   <= '0;
            cur_func  <= 2'd0;
            aes_func  <= 2'd0;
            aes_key   <= '0;
            aes_text  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_tag   <= '0;
            out_func  <= 2'd0;
            out_ct    <= '0;
            out_pt    <= '0;
            drop_cnt  <= 8'd0;
        end else begin
            if (in_valid && in_ready && (in_func == 2'd0))
                drop_cnt <= sat_inc8(drop_cnt);

            case (state)
                JQ_IDLE: begin
                    if (!fifo_empty) begin
                        aes_func <= head_job.func;
                        aes_key  <= head_job.key;
                        aes_text <= head_job.text;
                        cur_tag  <= TAGW'(head_job.tag);
                        cur_func <= head_job.func;
                        wdog     <= '0;
                        state    <= JQ_BUSY;
                    end
                end
                JQ_BUSY: begin
                    // Completion wins over a watchdog expiry on the same edge.
                    if (call_complete) begin
                        out_ct    <= ciphertext;
                        out_pt    <= plaintext;
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        out_tag   <= cur_tag;
                        out_func  <= cur_func;
                        aes_func  <= 2'd0;
                        state     <= JQ_DONE;
                    end else if (wdog == WDW'(TIMEOUT - 1)) begin
                        out_ct    <= '0;
                        out_pt    <= '0;
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        out_tag   <= cur_tag;
                        out_func  <= cur_func;
                        aes_func  <= 2'd0;
                        state     <= JQ_DONE;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                JQ_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= JQ_GAP;
                    end
                end
                JQ_GAP: begin
                    // aes_func stays 0 here so aes_build sees an edge between jobs.
                    state <= JQ_IDLE;
                end
                default: state <= JQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_job_queue.sv
// Randomized bench for aes_job_queue with a stub aes_build responder and a
// scoreboard of expected results in acceptance order.
module tb_aes_job_queue;
    import aes_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int TAGW    = 4;

    localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MIX = {4{32'h9e3779b9}};

    logic            eph1 = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_func = 2'd0;
    logic [127:0]    in_key = '0;
    logic [127:0]    in_text = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic [1:0]      aes_func;
    logic [127:0]    aes_key;
    logic [127:0]    aes_text;
    logic            call_complete = 1'b0;
    logic [127:0]    ciphertext = '0;
    logic [127:0]    plaintext = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [TAGW-1:0] out_tag;
    logic [1:0]      out_func;
    logic [127:0]    out_ct;
    logic [127:0]    out_pt;
    logic            out_err;
    logic [7:0]      drop_cnt;

    aes_job_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TAGW(TAGW)) dut (
        .eph1(eph1), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_key(in_key), .in_text(in_text), .in_tag(in_tag),
        .aes_func(aes_func), .aes_key(aes_key), .aes_text(aes_text),
        .call_complete(call_complete), .ciphertext(ciphertext), .plaintext(plaintext),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_func(out_func), .out_ct(out_ct), .out_pt(out_pt),
        .out_err(out_err), .drop_cnt(drop_cnt)
    );

    always #5 eph1 = ~eph1;

    int cyc = 0;
    always @(posedge eph1) cyc <= cyc + 1;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [1:0]      func;
        logic [127:0]    ct;
        logic [127:0]    pt;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   exp_drop = 0;
    logic stub_mute = 1'b0;
    logic hold_ready = 1'b0;
    int   lat_cur = 0;
    int   bsy_entry = 0;
    logic bsy_mute = 1'b0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Toy cipher for the stub: the FIPS-197 vector is honoured exactly,
    // anything else is an involutive XOR so decrypt(encrypt(x)) == x.
    function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] t);
        if (k == FK && t == FP) return FC;
        return t ^ k ^ MIX;
    endfunction

    function automatic logic [127:0] dec(input logic [127:0] k, input logic [127:0] t);
        if (k == FK && t == FC) return FP;
        return t ^ k ^ MIX;
    endfunction

    task automatic ref_job(input logic [1:0] f, input logic [127:0] k, input logic [127:0] t,
                           output logic [127:0] ct, output logic [127:0] pt);
        case (f)
            2'd1:    begin ct = enc(k, t); pt = t; end
            2'd2:    begin ct = t; pt = dec(k, t); end
            default: begin ct = enc(k, t); pt = dec(k, ct); end
        endcase
    endtask

    // Stub aes_build: random latency, occasional stray call_complete while idle.
    initial begin : stub
        logic         st_active;
        logic         st_done;
        int           st_cnt;
        logic [127:0] lk, lt, ct, pt;
        st_active = 0; st_done = 0; st_cnt = 0; lk = '0; lt = '0;
        forever begin
            @(negedge eph1);
            call_complete = 1'b0;
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            plaintext  = {$urandom, $urandom, $urandom, $urandom};
            if (!reset) begin
                st_active = 0; st_done = 0;
            end else if (aes_func == 2'd0) begin
                st_active = 0; st_done = 0;
                if ($urandom_range(0, 7) == 0) call_complete = 1'b1;
            end else begin
                if (!st_active) begin
                    st_active = 1; st_cnt = 0;
                    bsy_entry = cyc; bsy_mute = stub_mute;
                    lat_cur = $urandom_range(1, 6);
                    lk = aes_key; lt = aes_text;
                end
                if (!st_done && !bsy_mute) begin
                    st_cnt++;
                    if (st_cnt >= lat_cur) begin
                        chk("key_stable", aes_key, lk);
                        chk("text_stable", aes_text, lt);
                        ref_job(aes_func, aes_key, aes_text, ct, pt);
                        ciphertext = ct; plaintext = pt;
                        call_complete = 1'b1;
                        st_done = 1;
                    end
                end
            end
        end
    end

    // Monitor: drives out_ready, pops the scoreboard on each take.
    initial begin : monitor
        logic prev_ov;
        int   gap_chk;
        exp_t e;
        prev_ov = 0; gap_chk = 0;
        forever begin
            @(negedge eph1);
            if (!reset) begin
                prev_ov = 0; gap_chk = 0; out_ready = 1'b0;
            end else begin
                if (gap_chk > 0) begin
                    chk("gap_func", aes_func, 2'd0);
                    gap_chk--;
                end
                if (out_valid && !prev_ov)
                    chk("result_latency", cyc - bsy_entry, bsy_mute ? TIMEOUT : lat_cur);
                prev_ov = out_valid;
                out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (out_valid && out_ready) begin
                    gap_chk = 2;
                    if (sb.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_out: tag %h with no job outstanding", out_tag);
                    end else begin
                        e = sb.pop_front();
                        chk("out_tag", out_tag, e.tag);
                        chk("out_func", out_func, e.func);
                        chk("out_err", out_err, e.err);
                        chk("out_ct", out_ct, e.ct);
                        chk("out_pt", out_pt, e.pt);
                    end
                end
            end
        end
    end

    task automatic send(input logic [1:0] f, input logic [127:0] k, input logic [127:0] t,
                        input logic [TAGW-1:0] tg);
        exp_t e;
        in_valid = 1'b1; in_func = f; in_key = k; in_text = t; in_tag = tg;
        for (int i = 0; i < 300; i++) begin
            if (in_ready) begin
                if (f != 2'd0) begin
                    e.tag = tg; e.func = f; e.err = stub_mute;
                    if (stub_mute) begin e.ct = '0; e.pt = '0; end
                    else ref_job(f, k, t, e.ct, e.pt);
                    sb.push_back(e);
                end else if (exp_drop < 255) begin
                    exp_drop++;
                end
                @(negedge eph1);
                return;
            end
            @(negedge eph1);
        end
        total_cnt++;
        $display("FAIL accept_timeout: in_ready stayed %0d for tag %h", in_ready, tg);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600; i++) begin
            if (sb.size() == 0 && !out_valid) begin
                repeat (3) @(negedge eph1);
                return;
            end
            @(negedge eph1);
        end
        total_cnt++;
        $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_aes_func"}, aes_func, 2'd0);
        chk({pfx, "_aes_key"}, aes_key, '0);
        chk({pfx, "_aes_text"}, aes_text, '0);
        chk({pfx, "_out_valid"}, out_valid, 1'b0);
        chk({pfx, "_out_err"}, out_err, 1'b0);
        chk({pfx, "_out_tag"}, out_tag, '0);
        chk({pfx, "_out_func"}, out_func, 2'd0);
        chk({pfx, "_out_ct"}, out_ct, '0);
        chk({pfx, "_out_pt"}, out_pt, '0);
        chk({pfx, "_drop_cnt"}, drop_cnt, 8'd0);
        chk({pfx, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL sim_timeout: bench did not finish within time limit");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        logic seen_func;
        repeat (3) @(negedge eph1);
        chk_reset_outputs("rst");
        @(posedge eph1); #2 reset = 1'b1;
        @(negedge eph1);

        // FIPS-197 encrypt, issue one cycle after acceptance.
        repeat (2) @(negedge eph1);
        send(2'd1, FK, FP, 4'd5);
        in_valid = 1'b0;
        chk("fips_func_pre", aes_func, 2'd0);
        @(negedge eph1);
        chk("fips_func_issue", aes_func, 2'd1);
        wait_drain();

        // Decrypt round trip.
        send(2'd2, FK, FC, 4'd6);
        in_valid = 1'b0;
        wait_drain();

        // Illegal func offers.
        seen_func = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(2'd0, {4{$urandom}}, {4{$urandom}}, 4'(i));
            if (aes_func != 2'd0) seen_func = 1'b1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge eph1);
            if (aes_func != 2'd0 || out_valid) seen_func = 1'b1;
        end
        chk("illegal_activity", seen_func, 1'b0);
        chk("illegal_drop_cnt", drop_cnt, 8'(exp_drop));
        chk("illegal_in_ready", in_ready, 1'b1);

        // Backpressure: 4 queued + 1 issued fills the queue.
        hold_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            send(2'($urandom_range(1, 3)), {4{$urandom}}, {4{$urandom}}, 4'(i));
        in_valid = 1'b0;
        chk("bp_in_ready_full", in_ready, 1'b0);
        repeat (15) @(negedge eph1);
        chk("bp_in_ready_held", in_ready, 1'b0);
        chk("bp_out_valid_held", out_valid, 1'b1);
        hold_ready = 1'b0;
        wait_drain();

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge eph1);
            send(2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 4'($urandom));
        end
        in_valid = 1'b0;
        wait_drain();
        chk("rand_drop_cnt", drop_cnt, 8'(exp_drop));

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) send(2'd0, '0, '0, 4'd0);
        in_valid = 1'b0;
        @(negedge eph1);
        chk("drop_saturate", drop_cnt, 8'd255);

        // Watchdog timeout.
        stub_mute = 1'b1;
        send(2'd3, {4{$urandom}}, {4{$urandom}}, 4'd9);
        in_valid = 1'b0;
        wait_drain();
        stub_mute = 1'b0;

        // Reset with one job in flight and two queued.
        stub_mute = 1'b1;
        for (int i = 1; i <= 3; i++) send(2'd1, {4{$urandom}}, {4{$urandom}}, 4'(i));
        in_valid = 1'b0;
        repeat (2) @(negedge eph1);
        chk("pre_reset_busy", aes_func, 2'd1);
        @(posedge eph1); #2 reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        sb.delete();
        exp_drop = 0;
        stub_mute = 1'b0;
        @(posedge eph1); #2 reset = 1'b1;
        @(negedge eph1);
        chk("post_reset_in_ready", in_ready, 1'b1);
        seen_func = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge eph1);
            if (aes_func != 2'd0 || out_valid) seen_func = 1'b1;
        end
        chk("post_reset_no_stale", seen_func, 1'b0);

        // One clean job after reset.
        send(2'd1, FK, FP, 4'd7);
        in_valid = 1'b0;
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
